// File: rtl/softmax_mem_host.sv
// softmax_mem_host: input/result memories and launch sequencer for one softmax datapath
// Ports: host side writes input words, launches a run over [host_start_addr, host_end_addr), reads results;
// datapath side gets three combinational input-memory reads, init/start pulses and a stable range,
// and returns output beats on sm_done/sm_outp0..3.
module softmax_mem_host #(
  parameter int DATAWIDTH = 16,
  parameter int NUM = 4,
  parameter int ADDRSIZE = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     host_wr_en,
  input  logic [ADDRSIZE-1:0]      host_wr_addr,
  input  logic [DATAWIDTH*NUM-1:0] host_wr_data,
  input  logic                     host_go,
  input  logic [ADDRSIZE-1:0]      host_start_addr,
  input  logic [ADDRSIZE-1:0]      host_end_addr,
  output logic                     busy,
  output logic                     res_ready,
  output logic                     err,
  output logic [ADDRSIZE-1:0]      res_count,
  input  logic [ADDRSIZE-1:0]      res_rd_addr,
  output logic [DATAWIDTH*NUM-1:0] res_rd_data,
  input  logic [ADDRSIZE-1:0]      sm_addr,
  input  logic [ADDRSIZE-1:0]      sm_sub0_addr,
  input  logic [ADDRSIZE-1:0]      sm_sub1_addr,
  output logic [DATAWIDTH*NUM-1:0] sm_inp,
  output logic [DATAWIDTH*NUM-1:0] sm_sub0_inp,
  output logic [DATAWIDTH*NUM-1:0] sm_sub1_inp,
  output logic [ADDRSIZE-1:0]      sm_start_addr,
  output logic [ADDRSIZE-1:0]      sm_end_addr,
  output logic                     sm_init,
  output logic                     sm_start,
  input  logic                     sm_done,
  input  logic [DATAWIDTH-1:0]     sm_outp0,
  input  logic [DATAWIDTH-1:0]     sm_outp1,
  input  logic [DATAWIDTH-1:0]     sm_outp2,
  input  logic [DATAWIDTH-1:0]     sm_outp3
);
  localparam int W = DATAWIDTH * NUM;
  localparam int DEPTH = 1 << ADDRSIZE;
  localparam int WDW = $clog2(TIMEOUT) + 1;
  typedef enum logic [2:0] {S_IDLE, S_INIT, S_START, S_RUN, S_DONE, S_ERR} state_t;
  state_t r_state, w_next;
  logic [W-1:0] r_in_mem [DEPTH];
  logic [W-1:0] r_res_mem [DEPTH];
  logic [ADDRSIZE-1:0] r_start, r_end, r_count, w_n;
  logic [WDW-1:0] r_wd;
  logic [W-1:0] r_rd_data;
  logic w_idle_like, w_go, w_bad, w_cap, w_last, w_to;
  assign w_idle_like = r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR;
  assign w_go = host_go && w_idle_like;
  assign w_bad = host_end_addr <= host_start_addr;
  assign w_n = r_end - r_start;
  // beats past the expected count are dropped so res_count never exceeds N
  assign w_cap = r_state == S_RUN && sm_done && r_count != w_n;
  assign w_last = w_cap && (r_count + 1'b1) == w_n;
  assign w_to = r_wd == WDW'(TIMEOUT - 1);
  assign sm_inp = r_in_mem[sm_addr];
  assign sm_sub0_inp = r_in_mem[sm_sub0_addr];
  assign sm_sub1_inp = r_in_mem[sm_sub1_addr];
  assign sm_start_addr = r_start;
  assign sm_end_addr = r_end;
  assign res_count = r_count;
  assign res_rd_data = r_rd_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_start <= '0;
      r_end <= '0;
      r_count <= '0;
      r_wd <= '0;
      r_rd_data <= '0;
    end else begin
      r_state <= w_next;
      r_rd_data <= r_res_mem[res_rd_addr];
      r_wd <= r_state == S_RUN ? r_wd + 1'b1 : '0;
      if (w_go) begin
        r_start <= host_start_addr;
        r_end <= host_end_addr;
        r_count <= '0;
      end else if (w_cap) r_count <= r_count + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (host_wr_en && (r_state == S_IDLE || r_state == S_DONE)) r_in_mem[host_wr_addr] <= host_wr_data;
    if (w_cap) r_res_mem[r_count] <= {sm_outp3, sm_outp2, sm_outp1, sm_outp0};
  end
  always_comb begin
    w_next = r_state;
    if (w_go) w_next = w_bad ? S_ERR : S_INIT;
    else if (r_state == S_INIT) w_next = S_START;
    else if (r_state == S_START) w_next = S_RUN;
    else if (r_state == S_RUN) w_next = w_last ? S_DONE : w_to ? S_ERR : S_RUN;
  end
  always_comb begin
    busy = r_state == S_INIT || r_state == S_START || r_state == S_RUN;
    sm_init = r_state == S_INIT;
    sm_start = r_state == S_START;
    res_ready = r_state == S_DONE;
    err = r_state == S_ERR;
  end
endmodule

// File: doc/softmax_mem_host.md
Name: softmax_mem_host

Overview:
- Memory-side counterpart of the softmax datapath.
- Holds the input vector memory and answers the datapath's three read-address ports (max, first-stage sub, second-stage sub) combinationally.
- Sequences the datapath's init/start pulses, captures each output beat into a result memory and reports completion to the host.
- Sits between the host/test bus and one softmax instance.

Parameters:
- DATAWIDTH, 16, bits per lane.
- NUM, 4, lanes per memory word.
- ADDRSIZE, 8, address width of input and result memories; depth is 2^ADDRSIZE words each.
- TIMEOUT, 1024, max cycles in RUN before error.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- host_wr_en  in  1  write one input word
- host_wr_addr  in  ADDRSIZE  input memory write address
- host_wr_data  in  DATAWIDTH*NUM  input word, lane0 in LSBs
- host_go  in  1  launch pulse
- host_start_addr  in  ADDRSIZE  first input word
- host_end_addr  in  ADDRSIZE  one past last input word
- busy  out  1  run in progress
- res_ready  out  1  result set complete
- err  out  1  bad range or timeout
- res_count  out  ADDRSIZE  beats captured
- res_rd_addr  in  ADDRSIZE  result read address
- res_rd_data  out  DATAWIDTH*NUM  result word, 1-cycle latency
- sm_addr, sm_sub0_addr, sm_sub1_addr  in  ADDRSIZE each  datapath read addresses
- sm_inp, sm_sub0_inp, sm_sub1_inp  out  DATAWIDTH*NUM each  combinational reads of input memory at the matching address
- sm_start_addr, sm_end_addr  out  ADDRSIZE each  range held stable to datapath
- sm_init, sm_start  out  1 each  single-cycle pulses
- sm_done  in  1  output beat valid
- sm_outp0..sm_outp3  in  DATAWIDTH each  output lanes

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - state IDLE.
  - busy, res_ready, err, sm_init, sm_start = 0.
  - res_count, sm_start_addr, sm_end_addr, res_rd_data = 0.
  - Memories are not cleared.
- Input memory:
  - Written on host_wr_en only in IDLE or DONE; writes in any other state are dropped.
  - Three asynchronous read ports. A write and a read of the same address in the same cycle returns the old word.
- FSM states: IDLE, INIT, START, RUN, DONE, ERR.
- IDLE/DONE/ERR + host_go:
  - Latch start/end onto sm_start_addr and sm_end_addr.
  - Clear res_count, res_ready, err.
  - If host_end_addr <= host_start_addr, go to ERR and set err=1 next cycle; no pulses are issued.
  - Otherwise go to INIT.
- INIT: sm_init=1 for exactly this cycle; go to START.
- START: sm_start=1 for exactly this cycle; go to RUN.
- busy=1 in INIT, START and RUN.
- RUN:
  - Each cycle with sm_done=1, write {sm_outp3,sm_outp2,sm_outp1,sm_outp0} to res_mem[res_count] and increment res_count.
  - Expected beat count N = sm_end_addr - sm_start_addr.
  - When a capture brings res_count to N, go to DONE the next cycle.
  - Watchdog counter clears on entry to RUN and increments every RUN cycle. Reaching TIMEOUT goes to ERR with err=1.
- DONE: res_ready=1 and held until the next go or reset.
- ERR: err=1 and held until the next go or reset.
- sm_done outside RUN is ignored: no write, no count change.
- sm_done after N beats is ignored.
- host_go while busy is ignored.
- res_rd_data = res_mem[res_rd_addr], registered, readable in any state.
- Reset mid-RUN: returns to IDLE next edge with all outputs at reset values. Captured results in res_mem remain but res_count=0.

Test Plan:
- Single run: load words 0..3 with lanes (1,2,3,4); go with start=0, end=4 → sm_init high in cycle 1 after go and sm_start in cycle 2; exactly four sm_done beats captured; res_count=4; res_ready=1; res_rd_data at addr 0..3 matches the model output.
- Read ports: write 0x0004_0003_0002_0001 at addr 5; drive sm_addr=5, sm_sub0_addr=5, sm_sub1_addr=7 → sm_inp and sm_sub0_inp equal that word in the same cycle; sm_sub1_inp equals the addr 7 contents.
- Bad range: go with start=6, end=6 → err=1; no sm_init or sm_start pulse; busy stays 0.
- Timeout with TIMEOUT=16: hold sm_done=0 → ERR entered after 16 RUN cycles; err=1; busy=0.
- Protocol abuse: host_go and host_wr_en asserted during RUN → no restart; input memory unchanged. An extra sm_done after N beats → res_count stays N.
- Reset mid-RUN after 2 of 4 beats → busy, res_ready and res_count all 0 next cycle. A subsequent go runs to completion normally.
